// File: rtl/picomips_pkg.sv
// picomips_pkg
//   Types shared by the picoMIPS control path, the instruction decoder and
//   the verification bench.
//   opcode_t : 3-bit instruction opcode. All eight codes are assigned.
//              For the two conditional branches, bit 1 selects the flag
//              to test and bit 0 inverts the sense of the test.
//   state_t  : control sequencer states.
package picomips_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ALU  = 3'd1,
        LDI  = 3'd2,
        IN   = 3'd3,
        BEQ  = 3'd4,
        BNE  = 3'd5,
        JMP  = 3'd6,
        HALT = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        WAITIN = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle control FSM for the picoMIPS core. Each instruction takes a
//   FETCH cycle, where the opcode is captured, and an EXEC cycle, where the
//   PC strobe and register write are issued. IN may stall in WAITIN until the
//   external input is valid; HALT parks the core until reset.
//
//   Ports
//     clk          rising-edge system clock
//     reset        asynchronous active-high reset
//     opcode       opcode field from program memory (sampled in FETCH)
//     alu_z        ALU zero result (sampled in EXEC of ALU)
//     alu_n        ALU negative result (sampled in EXEC of ALU)
//     in_valid     external input data valid
//     ir_load      capture instruction word this cycle
//     PCincr       PC += 1
//     PCrelbranch  PC += Branchaddr
//     PCabsbranch  PC  = Branchaddr
//     reg_we       register-file write enable
//     in_ack       consume external input (single-cycle pulse)
//     halted       core stopped
//     icount       retired-instruction count, wraps modulo 2^CNTW
//
//   Strobes are combinational from the current state, the latched opcode,
//   the latched flags and in_valid. Reset drives the state to FETCH
//   immediately, so during reset only ir_load is high (holding PC at 0).
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int Psize = 6,
    parameter int OPW   = 3,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic            in_valid,
    output logic            ir_load,
    output logic            PCincr,
    output logic            PCrelbranch,
    output logic            PCabsbranch,
    output logic            reg_we,
    output logic            in_ack,
    output logic            halted,
    output logic [CNTW-1:0] icount
);

    state_t      state;
    state_t      state_nxt;
    opcode_t     op_q;
    logic [1:0]  flags_q;      // {n, z} from the most recent ALU op
    logic        flags_ld;
    logic        pc_step;
    logic        cond_flag;

    // Conditional branches test flags_q[op_q[1]]; BEQ/BNE both select z.
    assign cond_flag = flags_q[op_q[1]];

    always_comb begin
        state_nxt   = state;
        ir_load     = 1'b0;
        PCincr      = 1'b0;
        PCrelbranch = 1'b0;
        PCabsbranch = 1'b0;
        reg_we      = 1'b0;
        in_ack      = 1'b0;
        halted      = 1'b0;
        flags_ld    = 1'b0;

        case (state)
            FETCH: begin
                ir_load   = 1'b1;
                state_nxt = EXEC;
            end

            EXEC: begin
                state_nxt = FETCH;
                case (op_q)
                    NOP: begin
                        PCincr = 1'b1;
                    end
                    ALU: begin
                        reg_we   = 1'b1;
                        PCincr   = 1'b1;
                        flags_ld = 1'b1;
                    end
                    LDI: begin
                        reg_we = 1'b1;
                        PCincr = 1'b1;
                    end
                    IN: begin
                        if (in_valid) begin
                            reg_we = 1'b1;
                            in_ack = 1'b1;
                            PCincr = 1'b1;
                        end else begin
                            state_nxt = WAITIN;
                        end
                    end
                    BEQ: begin
                        if (cond_flag) PCrelbranch = 1'b1;
                        else           PCincr      = 1'b1;
                    end
                    BNE: begin
                        if (cond_flag) PCincr      = 1'b1;
                        else           PCrelbranch = 1'b1;
                    end
                    JMP: begin
                        PCabsbranch = 1'b1;
                    end
                    HALT: begin
                        state_nxt = HALTED;
                    end
                endcase
            end

            WAITIN: begin
                if (in_valid) begin
                    reg_we    = 1'b1;
                    in_ack    = 1'b1;
                    PCincr    = 1'b1;
                    state_nxt = FETCH;
                end
            end

            HALTED: begin
                halted = 1'b1;
            end
        endcase

        pc_step = PCincr | PCrelbranch | PCabsbranch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            op_q    <= NOP;
            flags_q <= '0;
            icount  <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                op_q <= opcode_t'(opcode);
            end
            if (flags_ld) begin
                flags_q <= {alu_n, alu_z};
            end
            if (pc_step) begin
                icount <= icount + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import picomips_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  opcode;
    logic        alu_z;
    logic        alu_n;
    logic        in_valid;
    logic        ir_load;
    logic        PCincr;
    logic        PCrelbranch;
    logic        PCabsbranch;
    logic        reg_we;
    logic        in_ack;
    logic        halted;
    logic [15:0] icount;

    int total = 0;
    int bad   = 0;

    // Instruction-level reference state.
    logic ref_z;
    int   ref_icount;

    pc_sequencer #(.Psize(6), .OPW(3), .CNTW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .in_valid    (in_valid),
        .ir_load     (ir_load),
        .PCincr      (PCincr),
        .PCrelbranch (PCrelbranch),
        .PCabsbranch (PCabsbranch),
        .reg_we      (reg_we),
        .in_ack      (in_ack),
        .halted      (halted),
        .icount      (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {ir_load, PCincr, PCrelbranch, PCabsbranch, reg_we, in_ack, halted}
    task automatic chk_out(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        logic       onehot;
        obs    = {ir_load, PCincr, PCrelbranch, PCabsbranch, reg_we, in_ack, halted};
        onehot = ($countones({PCincr, PCrelbranch, PCabsbranch}) <= 1);
        chk(tag, {25'd0, obs}, {25'd0, exp});
        chk({tag, "_onehot"}, {31'd0, onehot}, 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        alu_z    = 1'b1;
        #2;
        chk_out("reset_out", 7'b1000000);
        chk("reset_icount", {16'd0, icount}, 32'd0);
        next_cycle();
        reset      = 1'b0;
        ref_z      = 1'b0;
        ref_icount = 0;
    endtask

    task automatic fetch_cycle(input opcode_t op);
        opcode   = op;
        alu_z    = 1'($urandom);
        alu_n    = 1'($urandom);
        in_valid = 1'($urandom);
        @(negedge clk);
        chk_out("fetch", 7'b1000000);
        next_cycle();
    endtask

    // Runs one full instruction and checks every cycle against the
    // instruction-level semantics. nwait = cycles in_valid stays low for IN.
    task automatic do_instr(input opcode_t op, input logic az, input logic an, input int nwait);
        logic [6:0] exp;
        fetch_cycle(op);
        opcode = 3'($urandom);
        alu_z  = az;
        alu_n  = an;
        if (op == IN) in_valid = (nwait == 0);
        else          in_valid = 1'($urandom);
        case (op)
            NOP:     exp = 7'b0100000;
            ALU:     exp = 7'b0100100;
            LDI:     exp = 7'b0100100;
            IN:      exp = (nwait == 0) ? 7'b0100110 : 7'b0000000;
            BEQ:     exp = ref_z ? 7'b0010000 : 7'b0100000;
            BNE:     exp = ref_z ? 7'b0100000 : 7'b0010000;
            JMP:     exp = 7'b0001000;
            default: exp = 7'b0000000;
        endcase
        @(negedge clk);
        chk_out($sformatf("exec_%s", op.name()), exp);
        next_cycle();
        if (op == ALU) ref_z = az;
        if (exp[5:3] != 3'b000) ref_icount++;
        if (op == IN && nwait > 0) begin
            for (int k = 0; k < nwait; k++) begin
                in_valid = 1'b0;
                alu_z    = 1'($urandom);
                @(negedge clk);
                chk_out("waitin_stall", 7'b0000000);
                next_cycle();
            end
            in_valid = 1'b1;
            @(negedge clk);
            chk_out("waitin_done", 7'b0100110);
            next_cycle();
            ref_icount++;
        end
    endtask

    task automatic chk_icount(input string tag);
        logic [15:0] e;
        e = 16'(ref_icount);
        chk(tag, {16'd0, icount}, {16'd0, e});
    endtask

    initial begin
        opcode   = 3'd0;
        alu_z    = 1'b0;
        alu_n    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        apply_reset();

        // NOP x3: PCincr only in EXEC cycles
        do_instr(NOP, 1'b0, 1'b0, 0);
        do_instr(NOP, 1'b0, 1'b0, 0);
        do_instr(NOP, 1'b0, 1'b0, 0);
        chk("nop3_icount", {16'd0, icount}, 32'd3);

        // Latched-flag branches
        do_instr(ALU, 1'b1, 1'b0, 0);
        do_instr(BEQ, 1'b0, 1'b0, 0);   // alu_z now low: must still branch
        do_instr(BNE, 1'b0, 1'b1, 0);
        do_instr(LDI, 1'b0, 1'b0, 0);   // flags unchanged
        do_instr(BEQ, 1'b0, 1'b0, 0);
        do_instr(ALU, 1'b0, 1'b1, 0);
        do_instr(BEQ, 1'b1, 1'b0, 0);
        do_instr(BNE, 1'b1, 1'b0, 0);
        chk_icount("branch_icount");

        // IN waiting 5 cycles, then IN already valid
        do_instr(IN, 1'b0, 1'b0, 5);
        do_instr(IN, 1'b0, 1'b0, 0);
        chk_icount("in_icount");

        // JMP then HALT held for 20 cycles, then reset
        do_instr(JMP, 1'b0, 1'b0, 0);
        chk_icount("jmp_icount");
        do_instr(HALT, 1'b0, 1'b0, 0);
        for (int k = 0; k < 20; k++) begin
            opcode   = 3'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            chk_out("halted", 7'b0000001);
            next_cycle();
        end
        chk_icount("halt_icount");
        apply_reset();
        do_instr(NOP, 1'b0, 1'b0, 0);
        chk_icount("post_halt_icount");

        // Reset in the middle of WAITIN
        fetch_cycle(IN);
        in_valid = 1'b0;
        @(negedge clk);
        chk_out("midwait_exec", 7'b0000000);
        next_cycle();
        @(negedge clk);
        chk_out("midwait_stall", 7'b0000000);
        next_cycle();
        apply_reset();
        chk("midwait_icount", {16'd0, icount}, 32'd0);

        // Reset in the middle of EXEC(ALU), after z was set by an earlier ALU
        do_instr(ALU, 1'b1, 1'b1, 0);
        fetch_cycle(ALU);
        apply_reset();
        chk("midalu_icount", {16'd0, icount}, 32'd0);
        do_instr(BNE, 1'b1, 1'b0, 0);   // flags cleared: BNE must branch

        // Random instruction stream
        for (int i = 0; i < 1000; i++) begin
            opcode_t op;
            op = opcode_t'($urandom_range(0, 7));
            do_instr(op, 1'($urandom), 1'($urandom), (op == IN) ? int'($urandom_range(0, 3)) : 0);
            chk_icount("rand_icount");
            if (op == HALT) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk_out("rand_halted", 7'b0000001);
                    next_cycle();
                end
                apply_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
